// File: rtl/bus_initiator.sv
// bus_initiator: CPU-side initiator for the memory-mapped device bus.
// Takes one load/store at a time, runs a strobed bus cycle, waits for the
// device ack (or gives up after TIMEOUT_CYCLES) and returns one response.
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
module bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_error_q, resp_error_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_byte_en_q, bus_byte_en_d;
  logic          bus_rd_q, bus_rd_d;
  logic          bus_wr_q, bus_wr_d;
  logic [1:0]    size_q, size_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_bad;
  logic [3:0]    req_be;
  logic [31:0]   req_lanes;
  logic [31:0]   rdata_shifted;
  logic [31:0]   rdata_aligned;

  // Decode the incoming request: legality, lane enables and replicated write data.
  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b0000;
    req_lanes = req_wdata;
    case (req_size)
      2'd0: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_bad   = req_addr[0];
        req_be    = 4'b0011 << req_addr[1:0];
        req_lanes = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        req_bad   = (req_addr[1:0] != 2'b00);
        req_be    = 4'b1111;
        req_lanes = req_wdata;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Right-align the acked read data to its byte offset and trim it to the access size.
  always_comb begin
    rdata_shifted = bus_rdata >> {bus_addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    rdata_aligned = {24'h0, rdata_shifted[7:0]};
      2'd1:    rdata_aligned = {16'h0, rdata_shifted[15:0]};
      default: rdata_aligned = rdata_shifted;
    endcase
  end

  // Next-state and next-output logic for the IDLE -> ACCESS/RESP -> IDLE cycle.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_byte_en_d = bus_byte_en_q;
    bus_rd_d      = bus_rd_q;
    bus_wr_d      = bus_wr_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          cnt_d       = '0;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d       = ACCESS;
            bus_addr_d    = req_addr;
            bus_wdata_d   = req_lanes;
            bus_byte_en_d = req_be;
            bus_rd_d      = ~req_write;
            bus_wr_d      = req_write;
            size_d        = req_size;
          end
        end
      end
      ACCESS: begin
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          state_d       = RESP;
          resp_valid_d  = 1'b1;
          resp_error_d  = ~bus_ack;
          resp_rdata_d  = (bus_ack && bus_rd_q) ? rdata_aligned : 32'h0;
          bus_addr_d    = 32'h0;
          bus_wdata_d   = 32'h0;
          bus_byte_en_d = 4'b0000;
          bus_rd_d      = 1'b0;
          bus_wr_d      = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        cnt_d        = '0;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_error_q  <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_wdata_q   <= 32'h0;
      bus_byte_en_q <= 4'b0000;
      bus_rd_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      size_q        <= 2'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_byte_en_q <= bus_byte_en_d;
      bus_rd_q      <= bus_rd_d;
      bus_wr_q      <= bus_wr_d;
      size_q        <= size_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_error  = resp_error_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_byte_en = bus_byte_en_q;
  assign bus_rd      = bus_rd_q;
  assign bus_wr      = bus_wr_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed bench for bus_initiator. Each request is driven,
// the bus side is watched cycle by cycle (strobe counts, lanes, stability,
// response timing) and the results are held against hand-computed values.
module tb_bus_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int compared;
  int mismatched;

  int          obs_rd_cycles;
  int          obs_wr_cycles;
  int          obs_resp_cycle;
  int          obs_ready_busy;
  logic        obs_unstable;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic [31:0] obs_rdata;
  logic        obs_error;
  int          rst_resp_count;

  bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_byte_en (bus_byte_en),
    .bus_rd      (bus_rd),
    .bus_wr      (bus_wr),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [1:0] size, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_size  = size;
    req_wdata = wdata;
  endtask

  // Drive one request, play the device (ack after ack_after wait cycles, or
  // never when negative) and record what the bus and response side did.
  task automatic runRequest(input logic [31:0] addr, input logic wr,
                            input logic [1:0] size, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack_after);
    int strobes;
    logic done;
    obs_rd_cycles  = 0;
    obs_wr_cycles  = 0;
    obs_resp_cycle = -1;
    obs_ready_busy = 0;
    obs_unstable   = 1'b0;
    obs_addr       = 32'h0;
    obs_wdata      = 32'h0;
    obs_be         = 4'h0;
    obs_rdata      = 32'hFFFF_FFFF;
    obs_error      = 1'bx;
    strobes        = 0;
    done           = 1'b0;
    bus_rdata      = rdata;
    bus_ack        = 1'b0;
    applyStimulus(addr, wr, size, wdata);
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      bus_ack = 1'b0;
      if (req_ready) obs_ready_busy++;
      if (bus_rd) obs_rd_cycles++;
      if (bus_wr) obs_wr_cycles++;
      if (bus_rd || bus_wr) begin
        strobes++;
        if (strobes == 1) begin
          obs_addr  = bus_addr;
          obs_wdata = bus_wdata;
          obs_be    = bus_byte_en;
        end else if (bus_addr !== obs_addr || bus_wdata !== obs_wdata ||
                     bus_byte_en !== obs_be) begin
          obs_unstable = 1'b1;
        end
        if (ack_after >= 0 && strobes == ack_after + 1) bus_ack = 1'b1;
      end
      if (resp_valid) begin
        obs_resp_cycle = cyc;
        obs_rdata      = resp_rdata;
        obs_error      = resp_error;
        bus_ack        = 1'b0;
        done           = 1'b1;
      end else begin
        tick();
      end
    end
    bus_ack = 1'b0;
  endtask

  // After the response cycle, the pulse must end and the initiator be idle.
  task automatic checkAfterResp(input string name);
    tick();
    checkOutput({name, " resp_valid drop"}, 32'(resp_valid), 32'h0);
    checkOutput({name, " resp_rdata clear"}, resp_rdata, 32'h0);
    checkOutput({name, " resp_error clear"}, 32'(resp_error), 32'h0);
    checkOutput({name, " req_ready back"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_wdata  = 32'h0;
    bus_rdata  = 32'h0;
    bus_ack    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset resp_error", 32'(resp_error), 32'h0);
    checkOutput("reset bus_rd", 32'(bus_rd), 32'h0);
    checkOutput("reset bus_wr", 32'(bus_wr), 32'h0);
    checkOutput("reset bus_byte_en", 32'(bus_byte_en), 32'h0);
    checkOutput("reset bus_addr", bus_addr, 32'h0);
    checkOutput("reset bus_wdata", bus_wdata, 32'h0);

    $display("[TB] word load, two wait cycles");
    runRequest(32'h0001_0004, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 2);
    checkOutput("wload rd cycles", 32'(obs_rd_cycles), 32'd3);
    checkOutput("wload wr cycles", 32'(obs_wr_cycles), 32'd0);
    checkOutput("wload byte_en", 32'(obs_be), 32'hF);
    checkOutput("wload addr", obs_addr, 32'h0001_0004);
    checkOutput("wload stable", 32'(obs_unstable), 32'h0);
    checkOutput("wload busy ready", 32'(obs_ready_busy), 32'd0);
    checkOutput("wload resp cycle", 32'(obs_resp_cycle), 32'd4);
    checkOutput("wload rdata", obs_rdata, 32'hDEAD_BEEF);
    checkOutput("wload error", 32'(obs_error), 32'h0);
    checkOutput("wload strobe down", 32'(bus_rd), 32'h0);
    checkAfterResp("wload");

    $display("[TB] byte store, immediate ack");
    runRequest(32'h0001_0003, 1'b1, 2'd0, 32'h0000_00A5, 32'hFFFF_FFFF, 0);
    checkOutput("bstore wr cycles", 32'(obs_wr_cycles), 32'd1);
    checkOutput("bstore rd cycles", 32'(obs_rd_cycles), 32'd0);
    checkOutput("bstore byte_en", 32'(obs_be), 32'h8);
    checkOutput("bstore wdata", obs_wdata, 32'hA5A5_A5A5);
    checkOutput("bstore resp cycle", 32'(obs_resp_cycle), 32'd2);
    checkOutput("bstore rdata", obs_rdata, 32'h0);
    checkOutput("bstore error", 32'(obs_error), 32'h0);
    checkAfterResp("bstore");

    $display("[TB] half load, upper half");
    runRequest(32'h0001_0002, 1'b0, 2'd1, 32'h0, 32'h1234_5678, 1);
    checkOutput("hload byte_en", 32'(obs_be), 32'hC);
    checkOutput("hload rd cycles", 32'(obs_rd_cycles), 32'd2);
    checkOutput("hload resp cycle", 32'(obs_resp_cycle), 32'd3);
    checkOutput("hload rdata", obs_rdata, 32'h0000_1234);
    checkOutput("hload error", 32'(obs_error), 32'h0);
    checkAfterResp("hload");

    $display("[TB] byte load, lane 1");
    runRequest(32'h0001_0011, 1'b0, 2'd0, 32'h0, 32'h1122_3344, 0);
    checkOutput("bload byte_en", 32'(obs_be), 32'h2);
    checkOutput("bload rdata", obs_rdata, 32'h0000_0033);
    checkAfterResp("bload");

    $display("[TB] half store, lower half");
    runRequest(32'h0001_0020, 1'b1, 2'd1, 32'hFFFF_BEEF, 32'h0, 0);
    checkOutput("hstore byte_en", 32'(obs_be), 32'h3);
    checkOutput("hstore wdata", obs_wdata, 32'hBEEF_BEEF);
    checkOutput("hstore addr", obs_addr, 32'h0001_0020);
    checkAfterResp("hstore");

    $display("[TB] misaligned and illegal requests");
    runRequest(32'h0001_0001, 1'b0, 2'd2, 32'h0, 32'h5555_5555, 0);
    checkOutput("mis word strobes", 32'(obs_rd_cycles + obs_wr_cycles), 32'd0);
    checkOutput("mis word resp cycle", 32'(obs_resp_cycle), 32'd1);
    checkOutput("mis word error", 32'(obs_error), 32'h1);
    checkOutput("mis word rdata", obs_rdata, 32'h0);
    checkAfterResp("mis word");
    runRequest(32'h0001_0000, 1'b1, 2'd3, 32'h1234_5678, 32'h0, 0);
    checkOutput("size3 strobes", 32'(obs_rd_cycles + obs_wr_cycles), 32'd0);
    checkOutput("size3 resp cycle", 32'(obs_resp_cycle), 32'd1);
    checkOutput("size3 error", 32'(obs_error), 32'h1);
    checkAfterResp("size3");
    runRequest(32'h0001_0003, 1'b0, 2'd1, 32'h0, 32'h0, 0);
    checkOutput("mis half strobes", 32'(obs_rd_cycles + obs_wr_cycles), 32'd0);
    checkOutput("mis half error", 32'(obs_error), 32'h1);
    checkAfterResp("mis half");

    $display("[TB] ack never arrives");
    runRequest(32'h0002_0000, 1'b0, 2'd2, 32'h0, 32'hAAAA_5555, -1);
    checkOutput("timeout rd cycles", 32'(obs_rd_cycles), 32'd16);
    checkOutput("timeout resp cycle", 32'(obs_resp_cycle), 32'd17);
    checkOutput("timeout error", 32'(obs_error), 32'h1);
    checkOutput("timeout rdata", obs_rdata, 32'h0);
    checkAfterResp("timeout");

    $display("[TB] reset during a store");
    applyStimulus(32'h0001_0008, 1'b1, 2'd2, 32'h1357_9BDF);
    tick();
    req_valid = 1'b0;
    checkOutput("rst pre wr", 32'(bus_wr), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst wr drop", 32'(bus_wr), 32'h0);
    checkOutput("rst resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst req_ready", 32'(req_ready), 32'h1);
    rst_resp_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid) rst_resp_count++;
    end
    checkOutput("rst no resp", 32'(rst_resp_count), 32'd0);
    runRequest(32'h0001_000C, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D, 0);
    checkOutput("post rst resp cycle", 32'(obs_resp_cycle), 32'd2);
    checkOutput("post rst rdata", obs_rdata, 32'hCAFE_F00D);
    checkOutput("post rst error", 32'(obs_error), 32'h0);
    checkAfterResp("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
